multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control sequencer for the multi-cycle MIPS datapath. Decodes the opcode held in the IR and
//  steps the shared ALU, register file, PC and unified memory through FETCH..WRITEBACK.
//  Drives aluOp into the ALU control unit (00 add, 01 subtract, 10 use funct).
//  Stalls on a memory ready handshake and flags unsupported opcodes.
// PARAMETERS
//  ENABLE_ADDI  1  1: opcode 001000 (addi) supported; 0: treated as illegal
//  ENABLE_JUMP  1  1: opcode 000010 (j) supported; 0: treated as illegal
// PORTS
//  clk           in   1  single clock, all state updates on posedge
//  rstN          in   1  synchronous active-low reset
//  opcode        in   6  IR[31:26], valid from DECODE onward
//  memReady      in   1  memory completes the current read/write this cycle
//  pcWrite       out  1  unconditional PC load
//  pcWriteCond   out  1  PC load if ALU zero (beq)
//  iorD          out  1  0: memory address = PC, 1: ALUOut
//  memRead       out  1  memory read request, held until memReady
//  memWrite      out  1  memory write request, held until memReady
//  irWrite       out  1  load IR from memory data
//  memToReg      out  1  1: writeback data = MDR, 0: ALUOut
//  regDst        out  1  1: dest = rd, 0: dest = rt
//  regWrite      out  1  register file write enable
//  aluSrcA       out  1  0: PC, 1: register A
//  aluSrcB       out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  aluOp         out  2  to ALU control unit
//  pcSource      out  2  00 ALU result, 01 ALUOut, 10 jump target
//  illegalOp     out  1  one-cycle pulse on unsupported opcode in DECODE
//  instrDone     out  1  one-cycle pulse in the final state of every instruction
// BEHAVIOUR
//  - Moore outputs decoded from state; memory-gated strobes (irWrite, pcWrite in FETCH) also gated by memReady.
//  - rstN=0 at posedge: state<=FETCH. While rstN=0, every output is forced 0. First active cycle
//    after release is FETCH.
//  - States and transitions:
//    FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
//      If memReady: irWrite=1, pcWrite=1, go to DECODE. Otherwise stay with no PC/IR write.
//    DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
//      000000 EXEC; 100011 or 101011 MEMADR; 000100 BRANCH; 001000 ADDIEX; 000010 JUMP.
//      Any other opcode: illegalOp=1, go to FETCH (instruction is a NOP).
//    EXEC: aluSrcA=1, aluSrcB=00, aluOp=10, then RWB.
//    RWB: regDst=1, memToReg=0, regWrite=1, instrDone=1, then FETCH.
//    MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: lw to MEMRD, sw to MEMWR.
//    MEMRD: memRead=1, iorD=1. Stay until memReady, then MWB.
//    MWB: regDst=0, memToReg=1, regWrite=1, instrDone=1, then FETCH.
//    MEMWR: memWrite=1, iorD=1. Stay until memReady; instrDone=1 on the memReady cycle, then FETCH.
//    BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1, then FETCH.
//    ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00, then ADDIWB.
//    ADDIWB: regDst=0, memToReg=0, regWrite=1, instrDone=1, then FETCH.
//    JUMP: pcWrite=1, pcSource=10, instrDone=1, then FETCH.
//  - Latency with memReady tied 1: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each memReady=0
//    cycle adds one cycle.
//  - Unused outputs are 0 in every state, so no X reaches the datapath.
//  - opcode is sampled only in DECODE (and MEMADR for the lw/sw split). It is not re-sampled while stalled.
//  - rstN low mid-instruction abandons the instruction: no partial regWrite or memWrite after the reset edge.
//  - The state register is one-hot or binary, implementer's choice. An unreachable encoding recovers to FETCH.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//    aluOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), aluSrcB/pcSource encodings, state enum.
//  - One sub-module: ctrl_output_decode (combinational state + memReady -> control word).
//    The FSM next-state logic stays in this module.
// TESTING
//  - Reset: rstN=0 for 2 cycles with opcode=100011 -> all outputs 0; after release memRead=1, iorD=0, aluSrcB=01.
//  - R-type, memReady=1: opcode=000000 -> aluOp=10 in cycle 3, regWrite=1 and regDst=1 in cycle 4, instrDone once.
//  - lw with memReady low 3 cycles in MEMRD -> memRead/iorD held 4 cycles, single regWrite with memToReg=1, 8 cycles total.
//  - sw then beq: sw gives memWrite=1 with no regWrite; beq gives aluOp=01, pcWriteCond=1, pcSource=01 in cycle 3.
//  - Illegal opcode 111111 (and 001000 with ENABLE_ADDI=0) -> illegalOp one pulse in DECODE,
//    next cycle FETCH, no regWrite or memWrite.
//  - rstN pulsed low during MEMWR stall -> memWrite 0 from the reset edge, restart in FETCH, no instrDone.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
//   - opcode values recognised by the decoder
//   - aluOp, aluSrcB and pcSource encodings
//   - control state enumeration and the packed control word that the
//     output decoder hands back to the sequencer
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int STATE_W = 4;
  localparam int CTRL_W  = 17;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_RWB    = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MWB    = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control-word decoder for the multi-cycle sequencer.
// Ports:
//   state     in   4   current sequencer state (state_e encoding)
//   mem_ready in   1   memory handshake, gates FETCH strobes and MEMWR completion
//   ctrl      out  17  packed ctrl_word_t
// Every field not named for a state is 0, including for unused encodings.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  ctrl
);

  state_e     st;
  ctrl_word_t cw;

  assign st   = state_e'(state);
  assign ctrl = cw;

  always_comb begin
    cw = '0;
    case (st)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        // PC+4 and IR load only commit once the instruction word arrives
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_S2;
        cw.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        cw.reg_dst    = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.ior_d    = 1'b1;
      end
      S_MWB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write  = 1'b1;
        cw.ior_d      = 1'b1;
        cw.instr_done = mem_ready;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
        cw.instr_done    = 1'b1;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCSRC_JUMP;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath.
// Walks FETCH..WRITEBACK per instruction, stalls on memReady, flags
// unsupported opcodes in DECODE.
// Ports:
//   clk, rstN (sync, active-low), opcode[5:0] (IR[31:26]), memReady
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
//   regDst, regWrite, aluSrcA, aluSrcB[1:0], aluOp[1:0], pcSource[1:0],
//   illegalOp, instrDone
// Parameters ENABLE_ADDI / ENABLE_JUMP: 0 turns that opcode into illegal.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic       instrDone
);

  state_e            state_q;
  state_e            state_d;
  logic              op_legal;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_word_t        cw;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      OP_ADDI: op_legal = ENABLE_ADDI;
      OP_J:    op_legal = ENABLE_JUMP;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        // an unsupported opcode retires as a NOP straight back to FETCH
        state_d = S_FETCH;
        if (op_legal) begin
          case (opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = memReady ? S_MWB : S_MEMRD;
      S_MWB:    state_d = S_FETCH;
      S_MEMWR:  state_d = memReady ? S_FETCH : S_MEMWR;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  ctrl_output_decode u_decode (
    .state     (state_q),
    .mem_ready (memReady),
    .ctrl      (ctrl_raw)
  );

  // holding rstN low silences the datapath immediately, not one edge later
  assign cw = rstN ? ctrl_word_t'(ctrl_raw) : '0;

  assign pcWrite     = cw.pc_write;
  assign pcWriteCond = cw.pc_write_cond;
  assign iorD        = cw.ior_d;
  assign memRead     = cw.mem_read;
  assign memWrite    = cw.mem_write;
  assign irWrite     = cw.ir_write;
  assign memToReg    = cw.mem_to_reg;
  assign regDst      = cw.reg_dst;
  assign regWrite    = cw.reg_write;
  assign aluSrcA     = cw.alu_src_a;
  assign aluSrcB     = cw.alu_src_b;
  assign aluOp       = cw.alu_op;
  assign pcSource    = cw.pc_source;
  assign instrDone   = cw.instr_done;
  assign illegalOp   = rstN & (state_q == S_DECODE) & ~op_legal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. Two instances: default
// parameters (a) and ENABLE_ADDI=0 / ENABLE_JUMP=0 (b). Each step drives one
// cycle of inputs and queues the expected 18-bit control vector; a monitor
// pops and compares it mid-cycle.
// Vector bits: 17 pcWrite, 16 pcWriteCond, 15 iorD, 14 memRead, 13 memWrite,
// 12 irWrite, 11 memToReg, 10 regDst, 9 regWrite, 8 aluSrcA, 7:6 aluSrcB,
// 5:4 aluOp, 3:2 pcSource, 1 illegalOp, 0 instrDone.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a = 1'b0, rdy_a = 1'b1;
  logic [5:0] op_a   = 6'b100011;
  logic       rstn_b = 1'b0, rdy_b = 1'b1;
  logic [5:0] op_b   = 6'b000000;

  logic pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rwr_a, asa_a, ill_a, done_a;
  logic [1:0] asb_a, aop_a, pcs_a;
  logic pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rwr_b, asa_b, ill_b, done_b;
  logic [1:0] asb_b, aop_b, pcs_b;

  multicycle_control_fsm u_dut_a (
    .clk(clk), .rstN(rstn_a), .opcode(op_a), .memReady(rdy_a),
    .pcWrite(pcw_a), .pcWriteCond(pcwc_a), .iorD(iord_a), .memRead(mrd_a),
    .memWrite(mwr_a), .irWrite(irw_a), .memToReg(m2r_a), .regDst(rdst_a),
    .regWrite(rwr_a), .aluSrcA(asa_a), .aluSrcB(asb_a), .aluOp(aop_a),
    .pcSource(pcs_a), .illegalOp(ill_a), .instrDone(done_a)
  );

  multicycle_control_fsm #(.ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0)) u_dut_b (
    .clk(clk), .rstN(rstn_b), .opcode(op_b), .memReady(rdy_b),
    .pcWrite(pcw_b), .pcWriteCond(pcwc_b), .iorD(iord_b), .memRead(mrd_b),
    .memWrite(mwr_b), .irWrite(irw_b), .memToReg(m2r_b), .regDst(rdst_b),
    .regWrite(rwr_b), .aluSrcA(asa_b), .aluSrcB(asb_b), .aluOp(aop_b),
    .pcSource(pcs_b), .illegalOp(ill_b), .instrDone(done_b)
  );

  logic [17:0] obs_a, obs_b;
  assign obs_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rwr_a,
                  asa_a, asb_a, aop_a, pcs_a, ill_a, done_a};
  assign obs_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rwr_b,
                  asa_b, asb_b, aop_b, pcs_b, ill_b, done_b};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // expected control vectors, written directly from the state table
  function automatic logic [17:0] w_fetch(input logic rdy);
    logic [17:0] w = '0;
    w[14] = 1'b1; w[7:6] = 2'b01;
    w[17] = rdy;  w[12]  = rdy;
    return w;
  endfunction
  function automatic logic [17:0] w_decode(input logic ill);
    logic [17:0] w = '0;
    w[7:6] = 2'b11; w[1] = ill;
    return w;
  endfunction
  function automatic logic [17:0] w_exec();
    logic [17:0] w = '0;
    w[8] = 1'b1; w[5:4] = 2'b10;
    return w;
  endfunction
  function automatic logic [17:0] w_rwb();
    logic [17:0] w = '0;
    w[10] = 1'b1; w[9] = 1'b1; w[0] = 1'b1;
    return w;
  endfunction
  function automatic logic [17:0] w_memadr();
    logic [17:0] w = '0;
    w[8] = 1'b1; w[7:6] = 2'b10;
    return w;
  endfunction
  function automatic logic [17:0] w_memrd();
    logic [17:0] w = '0;
    w[14] = 1'b1; w[15] = 1'b1;
    return w;
  endfunction
  function automatic logic [17:0] w_mwb();
    logic [17:0] w = '0;
    w[11] = 1'b1; w[9] = 1'b1; w[0] = 1'b1;
    return w;
  endfunction
  function automatic logic [17:0] w_memwr(input logic rdy);
    logic [17:0] w = '0;
    w[13] = 1'b1; w[15] = 1'b1; w[0] = rdy;
    return w;
  endfunction
  function automatic logic [17:0] w_branch();
    logic [17:0] w = '0;
    w[8] = 1'b1; w[5:4] = 2'b01; w[16] = 1'b1; w[3:2] = 2'b01; w[0] = 1'b1;
    return w;
  endfunction
  function automatic logic [17:0] w_addiex();
    logic [17:0] w = '0;
    w[8] = 1'b1; w[7:6] = 2'b10;
    return w;
  endfunction
  function automatic logic [17:0] w_addiwb();
    logic [17:0] w = '0;
    w[9] = 1'b1; w[0] = 1'b1;
    return w;
  endfunction
  function automatic logic [17:0] w_jump();
    logic [17:0] w = '0;
    w[17] = 1'b1; w[3:2] = 2'b10; w[0] = 1'b1;
    return w;
  endfunction

  typedef struct {
    logic        sel;
    logic [17:0] exp;
  } sb_t;
  sb_t   sb_q[$];
  string tag_q[$];

  // drive one cycle on instance a (sel=0) or b (sel=1) and queue its expectation
  task automatic step(input logic sel, input string tag, input logic r,
                      input logic rdy, input logic [5:0] op, input logic [17:0] exp);
    sb_t e;
    @(negedge clk);
    if (sel) begin rstn_b = r; rdy_b = rdy; op_b = op; end
    else     begin rstn_a = r; rdy_a = rdy; op_a = op; end
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  sb_t   mon_e;
  string mon_t;
  always @(negedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_t = tag_q.pop_front();
      check(mon_t, {14'd0, (mon_e.sel ? obs_b : obs_a)}, {14'd0, mon_e.exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with a lw opcode present: everything silent
    step(0, "reset0", 1'b0, 1'b1, 6'b100011, 18'd0);
    step(0, "reset1", 1'b0, 1'b1, 6'b100011, 18'd0);

    // R-type
    step(0, "r_fetch",  1'b1, 1'b1, 6'b000000, w_fetch(1'b1));
    step(0, "r_decode", 1'b1, 1'b1, 6'b000000, w_decode(1'b0));
    step(0, "r_exec",   1'b1, 1'b1, 6'b000000, w_exec());
    step(0, "r_wb",     1'b1, 1'b1, 6'b000000, w_rwb());

    // lw with three stall cycles in MEMRD; opcode garbage while stalled
    step(0, "lw_fetch",  1'b1, 1'b1, 6'b100011, w_fetch(1'b1));
    step(0, "lw_decode", 1'b1, 1'b1, 6'b100011, w_decode(1'b0));
    step(0, "lw_memadr", 1'b1, 1'b1, 6'b100011, w_memadr());
    for (int i = 0; i < 3; i++)
      step(0, $sformatf("lw_stall%0d", i), 1'b1, 1'b0, 6'b111111, w_memrd());
    step(0, "lw_memrd",  1'b1, 1'b1, 6'b111111, w_memrd());
    step(0, "lw_wb",     1'b1, 1'b1, 6'b111111, w_mwb());

    // sw then beq
    step(0, "sw_fetch",  1'b1, 1'b1, 6'b101011, w_fetch(1'b1));
    step(0, "sw_decode", 1'b1, 1'b1, 6'b101011, w_decode(1'b0));
    step(0, "sw_memadr", 1'b1, 1'b1, 6'b101011, w_memadr());
    step(0, "sw_memwr",  1'b1, 1'b1, 6'b101011, w_memwr(1'b1));
    step(0, "beq_fetch",  1'b1, 1'b1, 6'b000100, w_fetch(1'b1));
    step(0, "beq_decode", 1'b1, 1'b1, 6'b000100, w_decode(1'b0));
    step(0, "beq_branch", 1'b1, 1'b1, 6'b000100, w_branch());

    // addi and j on the fully enabled instance
    step(0, "addi_fetch",  1'b1, 1'b1, 6'b001000, w_fetch(1'b1));
    step(0, "addi_decode", 1'b1, 1'b1, 6'b001000, w_decode(1'b0));
    step(0, "addi_ex",     1'b1, 1'b1, 6'b001000, w_addiex());
    step(0, "addi_wb",     1'b1, 1'b1, 6'b001000, w_addiwb());
    step(0, "j_fetch",  1'b1, 1'b1, 6'b000010, w_fetch(1'b1));
    step(0, "j_decode", 1'b1, 1'b1, 6'b000010, w_decode(1'b0));
    step(0, "j_jump",   1'b1, 1'b1, 6'b000010, w_jump());

    // fetch stall, then illegal opcode
    step(0, "ill_fetch_stall", 1'b1, 1'b0, 6'b111111, w_fetch(1'b0));
    step(0, "ill_fetch",       1'b1, 1'b1, 6'b111111, w_fetch(1'b1));
    step(0, "ill_decode",      1'b1, 1'b1, 6'b111111, w_decode(1'b1));
    step(0, "ill_next_fetch",  1'b1, 1'b1, 6'b101011, w_fetch(1'b1));

    // sw stalled in MEMWR, abandoned by reset
    step(0, "rst_sw_decode",  1'b1, 1'b1, 6'b101011, w_decode(1'b0));
    step(0, "rst_sw_memadr",  1'b1, 1'b1, 6'b101011, w_memadr());
    step(0, "rst_sw_stall0",  1'b1, 1'b0, 6'b101011, w_memwr(1'b0));
    step(0, "rst_sw_stall1",  1'b1, 1'b0, 6'b101011, w_memwr(1'b0));
    step(0, "rst_sw_reset",   1'b0, 1'b1, 6'b101011, 18'd0);
    step(0, "rst_sw_restart", 1'b1, 1'b1, 6'b000100, w_fetch(1'b1));
    step(0, "rst_sw_decode2", 1'b1, 1'b1, 6'b000100, w_decode(1'b0));

    // instance b: addi and j disabled
    step(1, "b_fetch0",   1'b1, 1'b1, 6'b001000, w_fetch(1'b1));
    step(1, "b_addi_ill", 1'b1, 1'b1, 6'b001000, w_decode(1'b1));
    step(1, "b_fetch1",   1'b1, 1'b1, 6'b000010, w_fetch(1'b1));
    step(1, "b_j_ill",    1'b1, 1'b1, 6'b000010, w_decode(1'b1));
    step(1, "b_fetch2",   1'b1, 1'b1, 6'b000000, w_fetch(1'b1));
    step(1, "b_r_decode", 1'b1, 1'b1, 6'b000000, w_decode(1'b0));
    step(1, "b_r_exec",   1'b1, 1'b1, 6'b000000, w_exec());
    step(1, "b_r_wb",     1'b1, 1'b1, 6'b000000, w_rwb());

    @(negedge clk);
    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
